// File: rtl/ast_bob_deinterlacer_if.sv
// Avalon-ST streaming bundle: one symbol per beat with packet framing.
//   data          : symbol
//   valid / ready : handshake, ready latency 0
//   startofpacket : first beat of a packet
//   endofpacket   : last beat of a packet
// master drives the payload, slave drives ready.
interface ast_bob_deinterlacer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  startofpacket;
  logic                  endofpacket;

  modport master (output data, valid, startofpacket, endofpacket, input ready);
  modport slave  (input data, valid, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/ast_bob_deinterlacer.sv
// Bob deinterlacer: forwards each video line and then replays it from a line
// buffer, rewrites control packets to doubled height / progressive, and passes
// all other packets through.
//   clock, reset : single clock, synchronous active-high reset
//   din          : Avalon-ST sink (interlaced fields from the BT.656 stage)
//   dout         : Avalon-ST source (progressive, line-doubled), registered
//   width_error  : sticky, a control packet carried width 0 or > MAX_WIDTH
module ast_bob_deinterlacer #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MAX_WIDTH     = 720,
  parameter int unsigned DEFAULT_WIDTH = 720
) (
  input  logic                          clock,
  input  logic                          reset,
  ast_bob_deinterlacer_if.slave         din,
  ast_bob_deinterlacer_if.master        dout,
  output logic                          width_error
);

  localparam int unsigned CW = $clog2(MAX_WIDTH + 1);
  localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CTRL_CAP, S_CTRL_EMIT, S_VID_PASS, S_VID_REP, S_OTHER_PASS
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           width_q, width_d;
  logic [CW-1:0]           cnt_q, cnt_d;       // write index in PASS, read index in REP
  logic [CW-1:0]           len_q, len_d;
  logic                    eop_seen_q, eop_seen_d;
  logic [8:0][3:0]         nib_q, nib_d;
  logic [3:0]              ncnt_q, ncnt_d;     // nibbles captured, then beat index while emitting
  logic [DATA_WIDTH-1:0]   dout_data_q, dout_data_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    dout_sop_q, dout_sop_d;
  logic                    dout_eop_q, dout_eop_d;
  logic                    werr_q, werr_d;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [DATA_WIDTH-1:0]   line_mem [MAX_WIDTH];

  logic                    out_ld_c, ready_c, wr_en_c, hdr_c, last_rep_c, width_ok_c;
  logic [3:0]              din_nib_c, emit_nib_c;
  logic [15:0]             cw_width_c, cw_height_c, h_out_c;
  logic [16:0]             h_dbl_c;

  assign out_ld_c  = !dout_valid_q || dout.ready;
  assign din_nib_c = din.data[3:0];

  // Rewritten control fields: width kept, height doubled with saturation.
  assign cw_width_c  = {nib_q[0], nib_q[1], nib_q[2], nib_q[3]};
  assign cw_height_c = {nib_q[4], nib_q[5], nib_q[6], nib_q[7]};
  assign h_dbl_c     = {cw_height_c, 1'b0};
  assign h_out_c     = h_dbl_c[16] ? 16'hFFFF : h_dbl_c[15:0];
  assign width_ok_c  = (cw_width_c != 16'd0) && (cw_width_c <= 16'(MAX_WIDTH));
  assign last_rep_c  = (cnt_q == len_q - CW'(1));

  // Nibble presented on each control-packet output beat.
  always_comb begin
    emit_nib_c = 4'h0;
    case (ncnt_q)
      4'd0:                   emit_nib_c = 4'hF;
      4'd1, 4'd2, 4'd3, 4'd4: emit_nib_c = nib_q[ncnt_q - 4'd1];
      4'd5:                   emit_nib_c = h_out_c[15:12];
      4'd6:                   emit_nib_c = h_out_c[11:8];
      4'd7:                   emit_nib_c = h_out_c[7:4];
      4'd8:                   emit_nib_c = h_out_c[3:0];
      default:                emit_nib_c = 4'h0;
    endcase
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    eop_seen_d   = eop_seen_q;
    nib_d        = nib_q;
    ncnt_d       = ncnt_q;
    dout_data_d  = dout_data_q;
    dout_valid_d = dout_valid_q && !out_ld_c;
    dout_sop_d   = dout_sop_q;
    dout_eop_d   = dout_eop_q;
    werr_d       = werr_q;
    ready_c      = 1'b0;
    wr_en_c      = 1'b0;
    hdr_c        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Only a header that must be forwarded waits for the output slot.
        ready_c = out_ld_c || !(din.valid && din.startofpacket && din_nib_c != 4'hF);
        hdr_c   = din.valid && din.startofpacket;
      end
      S_CTRL_CAP: begin
        ready_c = 1'b1;
        if (din.valid) begin
          if (ncnt_q < 4'd9) begin
            nib_d[ncnt_q] = din_nib_c;
            ncnt_d        = ncnt_q + 4'd1;
          end
          if (din.endofpacket) begin
            state_d = (ncnt_q >= 4'd8) ? S_CTRL_EMIT : S_IDLE;
            ncnt_d  = 4'd0;
          end
        end
      end
      S_CTRL_EMIT: begin
        if (out_ld_c) begin
          dout_valid_d = 1'b1;
          dout_data_d  = DATA_WIDTH'(emit_nib_c);
          dout_sop_d   = (ncnt_q == 4'd0);
          dout_eop_d   = (ncnt_q == 4'd9);
          ncnt_d       = ncnt_q + 4'd1;
          if (ncnt_q == 4'd9) begin
            state_d = S_IDLE;
            ncnt_d  = 4'd0;
            if (width_ok_c) width_d = CW'(cw_width_c);
            else            werr_d  = 1'b1;
          end
        end
      end
      S_VID_PASS: begin
        ready_c = out_ld_c;
        if (din.valid && ready_c) begin
          if (din.startofpacket) begin
            hdr_c = 1'b1;
          end else begin
            dout_valid_d = 1'b1;
            dout_data_d  = din.data;
            dout_sop_d   = 1'b0;
            dout_eop_d   = 1'b0;
            wr_en_c      = 1'b1;
            if (cnt_q == width_q - CW'(1) || din.endofpacket) begin
              len_d      = cnt_q + CW'(1);
              eop_seen_d = din.endofpacket;
              cnt_d      = '0;
              state_d    = S_VID_REP;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      S_VID_REP: begin
        // rd_data_q always holds buffer[cnt_q]; advancing cnt re-aims the read.
        if (out_ld_c) begin
          dout_valid_d = 1'b1;
          dout_data_d  = rd_data_q;
          dout_sop_d   = 1'b0;
          dout_eop_d   = last_rep_c && eop_seen_q;
          if (last_rep_c) begin
            cnt_d   = '0;
            state_d = eop_seen_q ? S_IDLE : S_VID_PASS;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_OTHER_PASS: begin
        ready_c = out_ld_c;
        if (din.valid && ready_c) begin
          if (din.startofpacket) begin
            hdr_c = 1'b1;
          end else begin
            dout_valid_d = 1'b1;
            dout_data_d  = din.data;
            dout_sop_d   = 1'b0;
            dout_eop_d   = din.endofpacket;
            if (din.endofpacket) state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Packet header routing, shared by IDLE and an SOP that abandons a packet.
    if (hdr_c && ready_c) begin
      if (din_nib_c == 4'hF) begin
        state_d = S_CTRL_CAP;
        ncnt_d  = 4'd0;
      end else begin
        dout_valid_d = 1'b1;
        dout_data_d  = din.data;
        dout_sop_d   = 1'b1;
        dout_eop_d   = din.endofpacket;
        cnt_d        = '0;
        if (din.endofpacket)      state_d = S_IDLE;
        else if (din_nib_c == 4'h0) state_d = S_VID_PASS;
        else                      state_d = S_OTHER_PASS;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      width_q      <= CW'(DEFAULT_WIDTH);
      cnt_q        <= '0;
      len_q        <= '0;
      eop_seen_q   <= 1'b0;
      nib_q        <= '0;
      ncnt_q       <= 4'd0;
      dout_data_q  <= '0;
      dout_valid_q <= 1'b0;
      dout_sop_q   <= 1'b0;
      dout_eop_q   <= 1'b0;
      werr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      eop_seen_q   <= eop_seen_d;
      nib_q        <= nib_d;
      ncnt_q       <= ncnt_d;
      dout_data_q  <= dout_data_d;
      dout_valid_q <= dout_valid_d;
      dout_sop_q   <= dout_sop_d;
      dout_eop_q   <= dout_eop_d;
      werr_q       <= werr_d;
    end
  end

  // Line buffer with synchronous read; bypass covers a one-pixel line whose
  // only pixel is written in the same cycle it is first read.
  always_ff @(posedge clock) begin
    if (wr_en_c) line_mem[AW'(cnt_q)] <= din.data;
    rd_data_q <= (wr_en_c && (cnt_q == cnt_d)) ? din.data : line_mem[AW'(cnt_d)];
  end

  assign din.ready          = ready_c && !reset;
  assign dout.data          = dout_data_q;
  assign dout.valid         = dout_valid_q;
  assign dout.startofpacket = dout_sop_q;
  assign dout.endofpacket   = dout_eop_q;
  assign width_error        = werr_q;

endmodule

// File: tb/tb_ast_bob_deinterlacer.sv
// Directed bench for ast_bob_deinterlacer. Vectors are text: each token is a
// hex beat, prefixed by S for startofpacket and/or E for endofpacket.
module tb_ast_bob_deinterlacer;

  localparam int SL = 96;

  typedef struct packed {
    logic [8*SL-1:0] stim;
    logic [8*SL-1:0] expv;
    logic            werr;
    logic            stress;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic width_error;

  always #5 clock = ~clock;

  ast_bob_deinterlacer_if #(.DATA_WIDTH(8)) din_if ();
  ast_bob_deinterlacer_if #(.DATA_WIDTH(8)) dout_if ();

  ast_bob_deinterlacer #(
    .DATA_WIDTH(8), .MAX_WIDTH(720), .DEFAULT_WIDTH(720)
  ) dut (
    .clock(clock),
    .reset(reset),
    .din(din_if),
    .dout(dout_if),
    .width_error(width_error)
  );

  int checks = 0;
  int errors = 0;
  int hold_err = 0;
  bit stress = 1'b0;
  bit abort = 1'b0;
  logic [9:0] pq[$];
  logic [9:0] stim_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] got[$];
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Text vector -> queue of {sop, eop, data}.
  task automatic parse(input logic [8*SL-1:0] s);
    logic [7:0] c;
    logic [7:0] val;
    bit sop, eop, intok;
    pq.delete();
    val = 8'h0; sop = 1'b0; eop = 1'b0; intok = 1'b0;
    for (int i = SL - 1; i >= 0; i--) begin
      c = s[i*8 +: 8];
      if (c == 8'h20) begin
        if (intok) pq.push_back({sop, eop, val});
        val = 8'h0; sop = 1'b0; eop = 1'b0; intok = 1'b0;
      end else if (c == "S") sop = 1'b1;
      else if (c == "E") eop = 1'b1;
      else if (c >= "0" && c <= "9") begin
        val = {val[3:0], 4'(c - "0")}; intok = 1'b1;
      end else if (c >= "A" && c <= "F") begin
        val = {val[3:0], 4'(c - "A" + 8'd10)}; intok = 1'b1;
      end
    end
    if (intok) pq.push_back({sop, eop, val});
  endtask

  // Source side: starts and ends on a falling edge.
  task automatic drive_beats();
    bit acc;
    for (int i = 0; i < stim_q.size(); i++) begin
      if (stress) begin
        repeat ($urandom_range(0, 2)) begin
          din_if.valid = 1'b0;
          @(negedge clock);
        end
      end
      din_if.valid         = 1'b1;
      din_if.data          = stim_q[i][7:0];
      din_if.startofpacket = stim_q[i][9];
      din_if.endofpacket   = stim_q[i][8];
      acc = 1'b0;
      for (int c = 0; c < 500 && !acc && !abort; c++) begin
        #4;
        acc = din_if.valid && din_if.ready;
        @(negedge clock);
      end
      if (abort) begin
        din_if.valid = 1'b0;
        return;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL drive: beat %0d never accepted, din_ready=%b expected 1", i, din_if.ready);
        din_if.valid = 1'b0;
        return;
      end
    end
    din_if.valid = 1'b0;
  endtask

  // Sink side: collects beats and watches that stalled outputs stay put.
  initial begin
    logic [9:0] hv;
    logic [9:0] cur;
    bit held;
    held = 1'b0;
    hv = '0;
    dout_if.ready = 1'b1;
    forever begin
      @(negedge clock);
      dout_if.ready = stress ? 1'($urandom_range(0, 1)) : 1'b1;
      #4;
      cur = {dout_if.startofpacket, dout_if.endofpacket, dout_if.data};
      if (dout_if.valid) begin
        if (held && cur != hv) hold_err++;
        if (dout_if.ready) begin
          got.push_back(cur);
          held = 1'b0;
        end else begin
          held = 1'b1;
          hv = cur;
        end
      end else begin
        if (held) hold_err++;
        held = 1'b0;
      end
    end
  end

  task automatic run_vec(input int id, input vec_t v);
    int n;
    stress = v.stress;
    got.delete();
    hold_err = 0;
    parse(v.stim);
    stim_q = pq;
    parse(v.expv);
    exp_q = pq;
    drive_beats();
    for (int c = 0; c < 600 && got.size() < exp_q.size(); c++) @(negedge clock);
    repeat (12) @(negedge clock);
    stress = 1'b0;
    check($sformatf("v%0d beat count", id), got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("v%0d beat %0d {sop,eop,data}", id, i), 32'(got[i]), 32'(exp_q[i]));
    check($sformatf("v%0d stall hold violations", id), hold_err, 0);
    check($sformatf("v%0d width_error", id), 32'(width_error), 32'(v.werr));
  endtask

  initial begin
    din_if.valid = 1'b0;
    din_if.data = 8'h00;
    din_if.startofpacket = 1'b0;
    din_if.endofpacket = 1'b0;

    vecs[0] = '{stim: "S0F 0 2 D 0 0 1 2 0 EB",
                expv: "S0F 0 2 D 0 0 2 4 0 E0", werr: 1'b0, stress: 1'b0};
    vecs[1] = '{stim: "S0F 0 0 0 4 0 0 0 1 E0 S00 1 2 3 4 5 6 7 E8",
                expv: "S0F 0 0 0 4 0 0 0 2 E0 S00 1 2 3 4 1 2 3 4 5 6 7 8 5 6 7 E8",
                werr: 1'b0, stress: 1'b0};
    vecs[2] = '{stim: "S00 1 2 3 4 5 6 7 E8",
                expv: "S00 1 2 3 4 1 2 3 4 5 6 7 8 5 6 7 E8", werr: 1'b0, stress: 1'b1};
    vecs[3] = '{stim: "S00 1 2 E3", expv: "S00 1 2 3 1 2 E3", werr: 1'b0, stress: 1'b0};
    vecs[4] = '{stim: "S03 A B EC", expv: "S03 A B EC", werr: 1'b0, stress: 1'b0};
    vecs[5] = '{stim: "S0F 1 2 3 4 E5 S00 1 2 3 4 E5",
                expv: "S00 1 2 3 4 1 2 3 4 5 E5", werr: 1'b0, stress: 1'b0};
    vecs[6] = '{stim: "S0F 0 0 0 0 0 0 0 1 E0 S00 1 2 3 4 5 E6",
                expv: "S0F 0 0 0 0 0 0 0 2 E0 S00 1 2 3 4 1 2 3 4 5 6 5 E6",
                werr: 1'b1, stress: 1'b0};
    vecs[7] = '{stim: "S0F 0 0 0 4 9 0 0 0 E0",
                expv: "S0F 0 0 0 4 F F F F E0", werr: 1'b1, stress: 1'b0};
    vecs[8] = '{stim: "S00 1 2 S03 A EB", expv: "S00 1 2 S03 A EB", werr: 1'b1, stress: 1'b0};

    // Reset state.
    repeat (3) @(negedge clock);
    #4;
    check("reset din_ready", 32'(din_if.ready), 0);
    check("reset dout_valid", 32'(dout_if.valid), 0);
    check("reset width_error", 32'(width_error), 0);
    @(negedge clock);
    reset = 1'b0;
    #4;
    check("idle din_ready", 32'(din_if.ready), 1);
    @(negedge clock);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a line replay.
    got.delete();
    parse("S00 1 2 3 4 5 6 7 E8");
    stim_q = pq;
    fork
      drive_beats();
    join_none
    for (int c = 0; c < 200 && got.size() < 6; c++) @(negedge clock);
    check("replay reached before reset", 32'(got.size() >= 6), 1);
    reset = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    #4;
    check("mid-replay reset dout_valid", 32'(dout_if.valid), 0);
    check("mid-replay reset din_ready", 32'(din_if.ready), 0);
    check("mid-replay reset width_error", 32'(width_error), 0);
    @(negedge clock);
    reset = 1'b0;
    abort = 1'b0;
    #4;
    check("post-reset din_ready", 32'(din_if.ready), 1);
    @(negedge clock);

    // Oversized width is reported but the default width stays in force.
    run_vec(9, '{stim: "S0F 0 3 F F 0 0 0 1 E0",
                 expv: "S0F 0 3 F F 0 0 0 2 E0", werr: 1'b1, stress: 1'b0});
    run_vec(10, '{stim: "S00 1 2 3 4 5 E6",
                  expv: "S00 1 2 3 4 5 6 1 2 3 4 5 E6", werr: 1'b1, stress: 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
